// File: rtl/conf_pkg.sv
// Shared constants and FSM state encoding for the framed configuration receiver.
package conf_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam int         CONF_BITS = 80;

  typedef enum logic [2:0] {
    IDLE,
    CHAN,
    PAYLOAD,
    CSUM,
    COMMIT
  } state_t;

endpackage

// File: rtl/conf_frame_rx_if.sv
// Byte-in / response-byte-out bundle between uart_rx, the receiver and the tx path.
interface conf_frame_rx_if;

  logic [7:0] i_data;
  logic       i_avail;
  logic [7:0] o_ack_data;
  logic       o_ack_valid;
  logic       i_ack_ready;

  modport master (
    output i_data, i_avail, i_ack_ready,
    input  o_ack_data, o_ack_valid
  );

  modport slave (
    input  i_data, i_avail, i_ack_ready,
    output o_ack_data, o_ack_valid
  );

endinterface

// File: rtl/rising_edge_detector.sv
// Registered rising-edge detector: o_rise is a one-cycle pulse one clock after i_sig rises.
module rising_edge_detector (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // Remember the previous level and register the 0->1 transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/conf_frame_rx.sv
// Framed configuration receiver: 0xA5, chan, payload, XOR checksum -> atomic slot commit.
// Optional response byte (ACK/NAK) on the interface when CFG_RX_ACK_EN is defined.
module conf_frame_rx
  import conf_pkg::*;
#(
  parameter int CH_NO       = 4,
  parameter int CONF_BYTES  = CONF_BITS / 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                           i_clk,
  input  logic                           _rst,
  conf_frame_rx_if.slave                 bus,
  output logic [CH_NO*CONF_BYTES*8-1:0]  o_ch_conf,
  output logic [CH_NO-1:0]               o_conf_upd,
  output logic                           o_err
);

  localparam int SLOT_W = CONF_BYTES * 8;
  localparam int CH_W   = (CH_NO > 1) ? $clog2(CH_NO) : 1;
  localparam int K_W    = (CONF_BYTES > 1) ? $clog2(CONF_BYTES) : 1;

  logic                    w_stb;
  logic [7:0]              r_byte;
  state_t                  r_state;
  state_t                  w_next;
  logic                    w_err;
  logic                    w_commit;
  logic                    w_chan_ld;
  logic                    w_pay_ld;
  logic                    w_tmo;
  logic [CH_W-1:0]         r_chan;
  logic [K_W-1:0]          r_k;
  logic [7:0]              r_xsum;
  logic [SLOT_W-1:0]       r_stage;
  logic [15:0]             r_tmo;
  logic [CH_NO*SLOT_W-1:0] r_ch_conf;
  logic [CH_NO-1:0]        r_upd;
  logic                    r_err;

  rising_edge_detector u_avail_edge (
    .i_clk   (i_clk),
    .i_rst_n (_rst),
    .i_sig   (bus.i_avail),
    .o_rise  (w_stb)
  );

  // State register.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle control; a strobe always takes priority over timeout.
  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_commit  = 1'b0;
    w_chan_ld = 1'b0;
    w_pay_ld  = 1'b0;
    w_tmo     = (r_tmo == 16'(TIMEOUT_CYC));
    case (r_state)
      IDLE: begin
        if (w_stb && r_byte == SYNC_BYTE) w_next = CHAN;
      end
      CHAN: begin
        if (w_stb) begin
          w_chan_ld = 1'b1;
          if ({24'd0, r_byte} < 32'(CH_NO)) begin
            w_next = PAYLOAD;
          end else begin
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end else if (w_tmo) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      PAYLOAD: begin
        if (w_stb) begin
          w_pay_ld = 1'b1;
          if (r_k == K_W'(CONF_BYTES - 1)) w_next = CSUM;
        end else if (w_tmo) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      CSUM: begin
        if (w_stb) begin
          if (r_byte == r_xsum) begin
            w_next = COMMIT;
          end else begin
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end else if (w_tmo) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Byte capture, inter-byte timeout, checksum and staging of the frame in flight.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_byte  <= '0;
      r_tmo   <= '0;
      r_chan  <= '0;
      r_k     <= '0;
      r_xsum  <= '0;
      r_stage <= '0;
    end else begin
      r_byte <= bus.i_data;
      if (r_state == IDLE || r_state == COMMIT || w_stb) r_tmo <= '0;
      else                                               r_tmo <= r_tmo + 16'd1;
      if (w_chan_ld) begin
        r_chan  <= r_byte[CH_W-1:0];
        r_xsum  <= r_byte;
        r_k     <= '0;
        r_stage <= '0;
      end
      if (w_pay_ld) begin
        r_stage[r_k*8 +: 8] <= r_byte;
        r_xsum              <= r_xsum ^ r_byte;
        r_k                 <= r_k + K_W'(1);
      end
    end
  end

  // Commit the staged frame into its slot only; update pulse and error pulse are registered.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_ch_conf <= '0;
      r_upd     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_err;
      r_upd <= '0;
      if (w_commit) begin
        for (int i = 0; i < CH_NO; i++) begin
          if (r_chan == CH_W'(i)) begin
            r_ch_conf[i*SLOT_W +: SLOT_W] <= r_stage;
            r_upd[i]                      <= 1'b1;
          end
        end
      end
    end
  end

  assign o_ch_conf  = r_ch_conf;
  assign o_conf_upd = r_upd;
  assign o_err      = r_err;

`ifdef CFG_RX_ACK_EN
  logic       r_ack_valid;
  logic [7:0] r_ack_data;

  // One-deep response register: a new result overwrites a pending one.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
    end else if (w_commit) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= ACK_BYTE;
    end else if (w_err) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= NAK_BYTE;
    end else if (bus.i_ack_ready) begin
      r_ack_valid <= 1'b0;
    end
  end

  assign bus.o_ack_valid = r_ack_valid;
  assign bus.o_ack_data  = r_ack_data;
`else
  logic w_unused_ack_ready;
  assign w_unused_ack_ready = bus.i_ack_ready;
  assign bus.o_ack_valid    = 1'b0;
  assign bus.o_ack_data     = '0;
`endif

endmodule
